// File: rtl/bcd.sv
// 4-bit ripple-carry adder/subtractor with registered sum and carry-out.
// Optional signed-overflow output Ovf is enabled by defining BCD_OVF_EN.
module bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
`ifdef BCD_OVF_EN
  output logic       Ovf,
`endif
  output logic       Cout
);

  logic [4:0] c;
  logic [3:0] bx;
  logic [3:0] sum_d;

  // Subtract as a + ~b + 1: invert b and feed op in as carry-in.
  always_comb begin
    c     = '0;
    sum_d = '0;
    bx    = b ^ {4{op}};
    c[0]  = op;
    for (int i = 0; i < 4; i++) begin
      sum_d[i] = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= 4'h0;
      Cout <= 1'b0;
    end else begin
      sum  <= sum_d;
      Cout <= c[4];
    end
  end

`ifdef BCD_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Ovf <= 1'b0;
    end else begin
      Ovf <= c[3] ^ c[4];
    end
  end
`endif

endmodule

// File: tb/tb_bcd.sv
// Self-checking bench for bcd: directed vector table, reset corner cases and
// random stimulus against an arithmetic reference model.
module tb_bcd;

  logic       clk;
  logic       rst;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sum;
  logic       Cout;
  logic       ovf_w;

  int checks = 0;
  int errors = 0;

  bcd dut (
    .clk  (clk),
    .rst  (rst),
    .op   (op),
    .a    (a),
    .b    (b),
    .sum  (sum),
`ifdef BCD_OVF_EN
    .Ovf  (ovf_w),
`endif
    .Cout (Cout)
  );

`ifndef BCD_OVF_EN
  assign ovf_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  // Reference: unsigned arithmetic for sum/Cout, signed range test for Ovf.
  function automatic logic [5:0] model(input logic mop, input logic [3:0] ma,
                                       input logic [3:0] mb);
    int ua, ub, r, sa, sb, sr;
    logic [3:0] s;
    logic co, ov;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    if (mop) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      co = (r > 15);
      sr = sa + sb;
    end
    s  = 4'((r + 16) % 16);
    ov = (sr > 7) || (sr < -8);
`ifndef BCD_OVF_EN
    ov = 1'b0;
`endif
    return {ov, co, s};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ovf=%b cout=%b sum=%0d, required ovf=%b cout=%b sum=%0d",
               name, got[5], got[4], got[3:0], exp[5], exp[4], exp[3:0]);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic ovf_exp;
`ifdef BCD_OVF_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    vecs.push_back('{1'b0, 4'd1,  4'd8,  4'd9,  1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd7,  4'd0,  4'd7,  1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd5,  4'd10, 4'd15, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd5,  4'd3,  4'd2,  1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd6,  4'd11, 4'd1,  1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd4,  4'd4,  4'd0,  1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd7,  4'd12, 4'd3,  1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd15, 4'd5,  4'd10, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd4,  4'd4,  4'd8,  1'b0, ovf_exp});
    vecs.push_back('{1'b1, 4'd3,  4'd5,  4'd14, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd15, 4'd1,  4'd0,  1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd0,  4'd1,  4'd15, 1'b0, 1'b0});
    // First entry: 1+8 = -7 signed? 1+(-8) = -7, no overflow.
    vecs[0].ovf = 1'b0;

    rst = 1'b1;
    op  = 1'b0;
    a   = 4'd0;
    b   = 4'd0;
    #1;
    check("reset_state", {ovf_w, Cout, sum}, 6'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Back-to-back directed vectors, op alternating every cycle.
    foreach (vecs[i]) begin
      op = vecs[i].op;
      a  = vecs[i].a;
      b  = vecs[i].b;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {ovf_w, Cout, sum},
            {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
      check($sformatf("vec%0d_model", i), {ovf_w, Cout, sum}, model(vecs[i].op, vecs[i].a,
                                                                    vecs[i].b));
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle with sum=9 held.
    op = 1'b0; a = 4'd1; b = 4'd8;
    @(posedge clk);
    #1;
    check("pre_reset_sum9", {ovf_w, Cout, sum}, 6'd9);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", {ovf_w, Cout, sum}, 6'd0);
    a = 4'd6; b = 4'd11;
    @(posedge clk);
    #1;
    check("reset_held_over_edge", {ovf_w, Cout, sum}, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("after_deassert_before_edge", {ovf_w, Cout, sum}, 6'd0);
    @(posedge clk);
    #1;
    check("first_capture_after_reset", {ovf_w, Cout, sum}, {1'b0, 1'b1, 4'd1});
    @(negedge clk);

    // Random stimulus against the model, one new operation per cycle.
    for (int k = 0; k < 300; k++) begin
      logic [5:0] exp_v;
      op = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      exp_v = model(op, a, b);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", k), {ovf_w, Cout, sum}, exp_v);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
